// File: rtl/retire_map.sv
// retire_map: in-order retirement stage and architectural map table.
// Retires the longest completed in-order prefix of the N ROB head slots,
// commits destination mappings, returns Told tags to the free list and
// pulses branch_mispredict (one FLUSH cycle) when a mispredicted branch retires.
// Optional build macro: RETIRE_MAP_STATS_EN adds retired_inst_total and
// mispredict_total counters.

`ifndef N
`define N 3
`endif
`ifndef ARCH_REG_SZ
`define ARCH_REG_SZ 32
`endif
`ifndef PHYS_REG_BITS
`define PHYS_REG_BITS 6
`endif

module retire_map #(
   parameter int unsigned N           = `N,
   parameter int unsigned ARCH_REG_SZ = `ARCH_REG_SZ,
   parameter int unsigned PREG_BITS   = `PHYS_REG_BITS
) (
   input  logic                                        clock,
   input  logic                                        reset,
   input  logic [N-1:0]                                rob_valid,
   input  logic [N-1:0]                                rob_complete,
   input  logic [N-1:0]                                rob_has_dest,
   input  logic [N-1:0][$clog2(ARCH_REG_SZ)-1:0]       rob_arch_reg,
   input  logic [N-1:0][PREG_BITS-1:0]                 rob_t_new,
   input  logic [N-1:0][PREG_BITS-1:0]                 rob_t_old,
   input  logic [N-1:0]                                rob_mispredict,
   output logic [$clog2(N+1)-1:0]                      retire_count,
   output logic [N-1:0]                                free_reg_request,
   output logic [N-1:0][PREG_BITS-1:0]                 retired_pregs,
   output logic                                        branch_mispredict,
`ifdef RETIRE_MAP_STATS_EN
   output logic [31:0]                                 retired_inst_total,
   output logic [31:0]                                 mispredict_total,
`endif
   output logic [ARCH_REG_SZ-1:0][PREG_BITS-1:0]       arch_map_mispredict_input
);

   localparam int unsigned AW = $clog2(ARCH_REG_SZ);
   localparam int unsigned CW = $clog2(N+1);

   typedef enum logic {RUN, FLUSH} state_e;

   state_e                                  state_q, state_d;
   logic [ARCH_REG_SZ-1:0][PREG_BITS-1:0]   arch_map_q, arch_map_d;
   logic [N-1:0]                            free_req_q, free_req_d;
   logic [N-1:0][PREG_BITS-1:0]             pregs_q, pregs_d;
   logic                                    bm_q, bm_d;
   logic [N-1:0]                            retire_c;
   logic                                    prefix_ok;
   logic                                    mispredict_c;
   logic [CW-1:0]                           count_c;

`ifdef RETIRE_MAP_STATS_EN
   logic [31:0] retired_total_q, retired_total_d;
   logic [31:0] mispredict_total_q, mispredict_total_d;
`endif

   // Retire set: in-order complete prefix, closed after a mispredicting slot; none in FLUSH
   always_comb begin
      retire_c  = '0;
      prefix_ok = (state_q == RUN);
      count_c   = '0;
      for (int k = 0; k < N; k++) begin
         if (prefix_ok && rob_valid[k] && rob_complete[k]) begin
            retire_c[k] = 1'b1;
            if (rob_mispredict[k]) prefix_ok = 1'b0;
         end else begin
            prefix_ok = 1'b0;
         end
         count_c = count_c + CW'(retire_c[k]);
      end
      mispredict_c = |(retire_c & rob_mispredict);
   end

   // Next state: map commits in slot order, free requests, recovery pulse, FSM
   always_comb begin
      arch_map_d = arch_map_q;
      free_req_d = '0;
      pregs_d    = '0;
      bm_d       = mispredict_c;
      state_d    = state_q;
      for (int k = 0; k < N; k++) begin
         if (retire_c[k] && rob_has_dest[k]) begin
            if (rob_arch_reg[k] != '0) arch_map_d[rob_arch_reg[k]] = rob_t_new[k];
            if (rob_t_old[k] != '0) begin
               free_req_d[k] = 1'b1;
               pregs_d[k]    = rob_t_old[k];
            end
         end
      end
      case (state_q)
         RUN:     if (mispredict_c) state_d = FLUSH;
         FLUSH:   state_d = RUN;
         default: state_d = RUN;
      endcase
   end

`ifdef RETIRE_MAP_STATS_EN
   // Statistics counters, wrapping modulo 2^32
   always_comb begin
      retired_total_d    = retired_total_q;
      mispredict_total_d = mispredict_total_q;
      if (state_q == RUN) retired_total_d = retired_total_q + 32'(count_c);
      if (bm_d) mispredict_total_d = mispredict_total_q + 32'd1;
   end

   // Statistics registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         retired_total_q    <= '0;
         mispredict_total_q <= '0;
      end else begin
         retired_total_q    <= retired_total_d;
         mispredict_total_q <= mispredict_total_d;
      end
   end

   assign retired_inst_total = retired_total_q;
   assign mispredict_total   = mispredict_total_q;
`endif

   // State and registered outputs; map resets to identity
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= RUN;
         free_req_q <= '0;
         pregs_q    <= '0;
         bm_q       <= 1'b0;
         for (int i = 0; i < ARCH_REG_SZ; i++) arch_map_q[i] <= PREG_BITS'(i);
      end else begin
         state_q    <= state_d;
         free_req_q <= free_req_d;
         pregs_q    <= pregs_d;
         bm_q       <= bm_d;
         arch_map_q <= arch_map_d;
      end
   end

   assign retire_count              = count_c;
   assign free_reg_request          = free_req_q;
   assign retired_pregs             = pregs_q;
   assign branch_mispredict         = bm_q;
   assign arch_map_mispredict_input = arch_map_q;

endmodule

// File: tb/tb_retire_map.sv
// Scoreboard bench for retire_map (N=3, 32 arch regs, 6-bit tags).
module tb_retire_map;

   localparam int unsigned N  = 3;
   localparam int unsigned AR = 32;
   localparam int unsigned PB = 6;

   logic                    clock;
   logic                    reset;
   logic [N-1:0]            rob_valid, rob_complete, rob_has_dest, rob_mispredict;
   logic [N-1:0][4:0]       rob_arch_reg;
   logic [N-1:0][PB-1:0]    rob_t_new, rob_t_old;
   logic [1:0]              retire_count;
   logic [N-1:0]            free_reg_request;
   logic [N-1:0][PB-1:0]    retired_pregs;
   logic                    branch_mispredict;
   logic [AR-1:0][PB-1:0]   arch_map;
`ifdef RETIRE_MAP_STATS_EN
   logic [31:0]             retired_inst_total, mispredict_total;
`endif

   typedef struct packed {
      logic [2:0]  req;
      logic [17:0] tags;
      logic        bm;
   } exp_t;

   exp_t sb_q[$];
   int   pass_cnt  = 0;
   int   total_cnt = 0;

   retire_map #(.N(N), .ARCH_REG_SZ(AR), .PREG_BITS(PB)) dut (
      .clock                     (clock),
      .reset                     (reset),
      .rob_valid                 (rob_valid),
      .rob_complete              (rob_complete),
      .rob_has_dest              (rob_has_dest),
      .rob_arch_reg              (rob_arch_reg),
      .rob_t_new                 (rob_t_new),
      .rob_t_old                 (rob_t_old),
      .rob_mispredict            (rob_mispredict),
      .retire_count              (retire_count),
      .free_reg_request          (free_reg_request),
      .retired_pregs             (retired_pregs),
      .branch_mispredict         (branch_mispredict),
`ifdef RETIRE_MAP_STATS_EN
      .retired_inst_total        (retired_inst_total),
      .mispredict_total          (mispredict_total),
`endif
      .arch_map_mispredict_input (arch_map)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Monitor: every visible free/recovery output must match the oldest expectation
   always @(negedge clock) begin
      if (reset === 1'b1 && (free_reg_request != '0 || branch_mispredict)) begin
         if (sb_q.size() == 0) begin
            check("unexpected_output", {28'd0, free_reg_request, branch_mispredict}, 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("free_reg_request", 32'(free_reg_request), 32'(e.req));
            check("retired_pregs", 32'(retired_pregs), 32'(e.tags));
            check("branch_mispredict", 32'(branch_mispredict), 32'(e.bm));
         end
      end
   end

   task automatic idle();
      rob_valid = '0; rob_complete = '0; rob_has_dest = '0; rob_mispredict = '0;
      rob_arch_reg = '0; rob_t_new = '0; rob_t_old = '0;
   endtask

   task automatic set_slot(input int k, input logic v, input logic c, input logic hd,
                           input logic [4:0] ar, input logic [5:0] tn, input logic [5:0] to,
                           input logic mp);
      rob_valid[k] = v; rob_complete[k] = c; rob_has_dest[k] = hd;
      rob_arch_reg[k] = ar; rob_t_new[k] = tn; rob_t_old[k] = to; rob_mispredict[k] = mp;
   endtask

   // Check retire_count now, queue the expected next-cycle output, advance one cycle
   task automatic step(input logic [1:0] exp_cnt, input logic [2:0] ereq,
                       input logic [17:0] etags, input logic ebm);
      exp_t e;
      #1;
      check("retire_count", 32'(retire_count), 32'(exp_cnt));
      if (ereq != '0 || ebm) begin
         e.req = ereq; e.tags = etags; e.bm = ebm;
         sb_q.push_back(e);
      end
      @(posedge clock); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      idle();
      repeat (2) @(negedge clock);
      check("reset_map5", 32'(arch_map[5]), 32'd5);
      check("reset_map31", 32'(arch_map[31]), 32'd31);
      check("reset_free_req", 32'(free_reg_request), 32'd0);
      check("reset_pregs", 32'(retired_pregs), 32'd0);
      check("reset_bm", 32'(branch_mispredict), 32'd0);
      check("reset_count", 32'(retire_count), 32'd0);
      reset = 1'b1;
      @(posedge clock); #1;

      // Full group of three
      set_slot(0, 1, 1, 1, 5'd3, 6'd40, 6'd3, 0);
      set_slot(1, 1, 1, 1, 5'd4, 6'd41, 6'd4, 0);
      set_slot(2, 1, 1, 1, 5'd7, 6'd42, 6'd7, 0);
      step(2'd3, 3'b111, {6'd7, 6'd4, 6'd3}, 1'b0);
      idle();
      check("map3", 32'(arch_map[3]), 32'd40);
      check("map4", 32'(arch_map[4]), 32'd41);
      check("map7", 32'(arch_map[7]), 32'd42);

      // Slot 1 incomplete blocks slot 2
      set_slot(0, 1, 1, 1, 5'd10, 6'd43, 6'd10, 0);
      set_slot(1, 1, 0, 1, 5'd11, 6'd44, 6'd11, 0);
      set_slot(2, 1, 1, 1, 5'd12, 6'd45, 6'd12, 0);
      step(2'd1, 3'b001, {6'd0, 6'd0, 6'd10}, 1'b0);
      idle();
      check("map10", 32'(arch_map[10]), 32'd43);
      check("map11", 32'(arch_map[11]), 32'd11);
      check("map12", 32'(arch_map[12]), 32'd12);

      // Same arch reg twice: youngest wins
      set_slot(0, 1, 1, 1, 5'd9, 6'd50, 6'd9, 0);
      set_slot(1, 1, 1, 1, 5'd9, 6'd51, 6'd50, 0);
      step(2'd2, 3'b011, {6'd0, 6'd50, 6'd9}, 1'b0);
      idle();
      check("map9", 32'(arch_map[9]), 32'd51);

      // Slot 1 mispredicts; slot 2 must not retire
      set_slot(0, 1, 1, 1, 5'd13, 6'd52, 6'd13, 0);
      set_slot(1, 1, 1, 1, 5'd14, 6'd53, 6'd14, 1);
      set_slot(2, 1, 1, 1, 5'd15, 6'd54, 6'd15, 0);
      step(2'd2, 3'b011, {6'd0, 6'd14, 6'd13}, 1'b1);
      check("flush_map13", 32'(arch_map[13]), 32'd52);
      check("flush_map14", 32'(arch_map[14]), 32'd53);
      check("flush_map15", 32'(arch_map[15]), 32'd15);
      // FLUSH cycle: stale valid inputs must not retire
      step(2'd0, 3'b000, 18'd0, 1'b0);
      idle();
      check("post_flush_map15", 32'(arch_map[15]), 32'd15);
      set_slot(0, 1, 1, 1, 5'd15, 6'd54, 6'd15, 0);
      step(2'd1, 3'b001, {6'd0, 6'd0, 6'd15}, 1'b0);
      idle();
      check("resume_map15", 32'(arch_map[15]), 32'd54);

      // Arch reg 0 with Told 0: no remap, no free
      set_slot(0, 1, 1, 1, 5'd0, 6'd55, 6'd0, 0);
      step(2'd1, 3'b000, 18'd0, 1'b0);
      idle();
      check("map0", 32'(arch_map[0]), 32'd0);

      // Slot 0 invalid, then slot 0 incomplete: nothing retires
      set_slot(1, 1, 1, 1, 5'd16, 6'd56, 6'd16, 0);
      step(2'd0, 3'b000, 18'd0, 1'b0);
      set_slot(0, 1, 0, 1, 5'd17, 6'd57, 6'd17, 0);
      step(2'd0, 3'b000, 18'd0, 1'b0);
      idle();
      check("map16", 32'(arch_map[16]), 32'd16);

      // Reset mid-group
      set_slot(0, 1, 1, 1, 5'd20, 6'd58, 6'd20, 0);
      #1;
      check("pre_reset_count", 32'(retire_count), 32'd1);
      reset = 1'b0;
      @(posedge clock); #1;
      idle();
      @(negedge clock);
      check("rst_map3", 32'(arch_map[3]), 32'd3);
      check("rst_map9", 32'(arch_map[9]), 32'd9);
      check("rst_map20", 32'(arch_map[20]), 32'd20);
      check("rst_free_req", 32'(free_reg_request), 32'd0);
      check("rst_bm", 32'(branch_mispredict), 32'd0);
      reset = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
